vga_roi_analyzer: RTL and testbench

- Parametrised successor to the QVGA-on-VGA display/threshold block.
- Generates VGA timing, reads a centred frame buffer and displays it in colour, grayscale or binary mode.
- Counts dark pixels inside a runtime-programmable rectangular ROI over exactly one full frame per request, with start/done handshake and a latched hit result.
- Sits between the camera frame buffer (synchronous 1-cycle read) and the VGA pins; results feed the parking controller.

---
 rtl/vga_roi_analyzer.sv | 222 ++++++++++++++++++++++
 tb/tb_vga_roi_analyzer.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_roi_analyzer.sv
// VGA raster generator with centred frame-buffer display (colour / gray /
// binary / binary+ROI overlay) and a one-frame dark-pixel ROI measurement.
module vga_roi_analyzer #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int IMG_W       = 320,
  parameter int IMG_H       = 240,
  parameter int IMG_X0      = 160,
  parameter int IMG_Y0      = 120,
  parameter int CW          = 4,
  parameter int ADDR_W      = 17,
  parameter int CNT_W       = 17,
  parameter int SYNC_ACTIVE = 0
) (
  input  logic              clk25,
  input  logic              rst,
  output logic [ADDR_W-1:0] frame_addr,
  input  logic [3*CW-1:0]   frame_pixel,
  input  logic [1:0]        mode,
  input  logic [CW-1:0]     threshold,
  input  logic [9:0]        roi_x0,
  input  logic [9:0]        roi_x1,
  input  logic [9:0]        roi_y0,
  input  logic [9:0]        roi_y1,
  input  logic [CNT_W-1:0]  hit_level,
  input  logic              algo_start,
  output logic              algo_busy,
  output logic              algo_done,
  output logic [CNT_W-1:0]  dark_count,
  output logic              result,
  output logic [9:0]        h_cnt,
  output logic [9:0]        v_cnt,
  output logic [CW-1:0]     vga_red,
  output logic [CW-1:0]     vga_green,
  output logic [CW-1:0]     vga_blue,
  output logic              vga_hsync,
  output logic              vga_vsync
);

  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] IX0    = 10'(IMG_X0);
  localparam logic [9:0] IX1    = 10'(IMG_X0 + IMG_W);
  localparam logic [9:0] IY0    = 10'(IMG_Y0);
  localparam logic [9:0] IY1    = 10'(IMG_Y0 + IMG_H);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(IMG_W * IMG_H - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
  localparam logic              SYNC_ON   = 1'(SYNC_ACTIVE);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_MEASURE, S_DONE} state_t;

  logic [9:0]        h_q, h_d, v_q, v_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              v_in_img0, in_img0, roi0, hs0, vs0;
  logic              in_img1_q, roi1_q, hs1_q, vs1_q;
  logic [CW-1:0]     r1, g1, b1, gray1, bw1;
  logic              dark1;
  logic [CW-1:0]     red_d, green_d, blue_d;
  logic [CW-1:0]     red_q, green_q, blue_q;
  logic              hsync_q, vsync_q;
  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q, dark_q;
  logic              busy_q, done_q, result_q;

  // Free-running raster counters
  always_comb begin
    h_d = h_q + 10'd1;
    v_d = v_q;
    if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
    end
  end

  // Raster counter registers
  always_ff @(posedge clk25) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Stage 0: image window, ROI membership, sync windows, next read address
  always_comb begin
    v_in_img0 = (v_q >= IY0) && (v_q < IY1);
    in_img0   = v_in_img0 && (h_q >= IX0) && (h_q < IX1);
    roi0      = in_img0 && (h_q >= roi_x0) && (h_q <= roi_x1)
                        && (v_q >= roi_y0) && (v_q <= roi_y1);
    hs0       = (h_q >= HS_BEG) && (h_q < HS_END);
    vs0       = (v_q >= VS_BEG) && (v_q < VS_END);
    addr_d    = addr_q;
    // wrap after the last image pixel so the address never leaves the buffer
    if (!v_in_img0)   addr_d = '0;
    else if (in_img0) addr_d = (addr_q == ADDR_LAST) ? '0 : addr_q + 1'b1;
  end

  // Frame-buffer address register and stage-1 alignment of stage-0 flags
  always_ff @(posedge clk25) begin
    if (rst) begin
      addr_q    <= '0;
      in_img1_q <= 1'b0;
      roi1_q    <= 1'b0;
      hs1_q     <= 1'b0;
      vs1_q     <= 1'b0;
    end else begin
      addr_q    <= addr_d;
      in_img1_q <= in_img0;
      roi1_q    <= roi0;
      hs1_q     <= hs0;
      vs1_q     <= vs0;
    end
  end

  // Stage 1: pixel conversion and display-mode selection
  always_comb begin
    r1      = frame_pixel[3*CW-1:2*CW];
    g1      = frame_pixel[2*CW-1:CW];
    b1      = frame_pixel[CW-1:0];
    gray1   = (r1 >> 2) + (g1 >> 1) + (b1 >> 2);
    dark1   = (gray1 <= threshold);
    bw1     = dark1 ? '0 : '1;
    red_d   = '0;
    green_d = '0;
    blue_d  = '0;
    if (in_img1_q) begin
      case (mode)
        2'd0: begin red_d = r1; green_d = g1; blue_d = b1; end
        2'd1: begin red_d = gray1; green_d = gray1; blue_d = gray1; end
        2'd2: begin red_d = bw1; green_d = bw1; blue_d = bw1; end
        default: begin
          if (dark1 && roi1_q) begin
            red_d = '0; green_d = '0; blue_d = '1;
          end else begin
            red_d = bw1; green_d = bw1; blue_d = bw1;
          end
        end
      endcase
    end
  end

  // Stage 2: registered pixel and sync outputs
  always_ff @(posedge clk25) begin
    if (rst) begin
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
      hsync_q <= ~SYNC_ON;
      vsync_q <= ~SYNC_ON;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      hsync_q <= hs1_q ? SYNC_ON : ~SYNC_ON;
      vsync_q <= vs1_q ? SYNC_ON : ~SYNC_ON;
    end
  end

  // Measurement FSM: arm on request, count one full frame, latch result
  always_ff @(posedge clk25) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dark_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (algo_start) begin
            state_q  <= S_ARMED;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            done_q   <= 1'b0;
            result_q <= 1'b0;
          end
        end
        S_ARMED: begin
          if (h_q == '0 && v_q == '0) state_q <= S_MEASURE;
        end
        default: begin
          if (roi1_q && dark1 && cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
          // h=2 on the first line below the image: last stage-1 pixel counted
          if (v_q == IY1 && h_q == 10'd2) begin
            state_q  <= S_DONE;
            dark_q   <= cnt_q;
            result_q <= (cnt_q >= hit_level);
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
          end
        end
      endcase
    end
  end

  assign frame_addr = addr_q;
  assign h_cnt      = h_q;
  assign v_cnt      = v_q;
  assign vga_red    = red_q;
  assign vga_green  = green_q;
  assign vga_blue   = blue_q;
  assign vga_hsync  = hsync_q;
  assign vga_vsync  = vsync_q;
  assign algo_busy  = busy_q;
  assign algo_done  = done_q;
  assign dark_count = dark_q;
  assign result     = result_q;

endmodule

// File: tb/tb_vga_roi_analyzer.sv
// Self-checking bench for vga_roi_analyzer on a reduced raster geometry.
module tb_vga_roi_analyzer;

  localparam int HA = 40, HFP = 2, HS = 4, HBP = 2, HT = 48;
  localparam int VA = 30, VFP = 2, VS = 2, VBP = 2, VT = 36;
  localparam int IW = 20, IH = 14, IX = 10, IY = 8;
  localparam int FRAME = HT * VT;

  logic        clk = 1'b0;
  logic        rst;
  logic [16:0] frame_addr;
  logic [11:0] fb_pix;
  logic [1:0]  mode;
  logic [3:0]  threshold;
  logic [9:0]  roi_x0, roi_x1, roi_y0, roi_y1;
  logic [16:0] hit_level;
  logic [7:0]  hit8;
  logic        algo_start;
  logic        algo_busy, algo_done, result;
  logic [16:0] dark_count;
  logic [9:0]  h_cnt, v_cnt;
  logic [3:0]  vga_red, vga_green, vga_blue;
  logic        vga_hsync, vga_vsync;
  logic [16:0] s_frame_addr;
  logic        s_busy, s_done, s_result;
  logic [7:0]  s_dark;
  logic [9:0]  s_h, s_v;
  logic [3:0]  s_r, s_g, s_b;
  logic        s_hs, s_vs;

  logic        pat_addr;
  logic [11:0] fb_const;
  logic        sb_en = 1'b0;
  int          mh, mv;
  int          n_tests = 0, n_fail = 0;
  logic [13:0] sb_q[$];
  logic [13:0] sb_e;

  typedef struct {int cnt; logic res; int cnt8; logic res8;} meas_t;
  meas_t mq[$];

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  thr;
    logic [11:0] pix;
    logic [11:0] exp_in;
    logic [11:0] exp_out;
  } pv_t;

  vga_roi_analyzer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .IMG_W(IW), .IMG_H(IH), .IMG_X0(IX), .IMG_Y0(IY),
    .CW(4), .ADDR_W(17), .CNT_W(17), .SYNC_ACTIVE(0)
  ) u_dut (
    .clk25(clk), .rst(rst), .frame_addr(frame_addr), .frame_pixel(fb_pix),
    .mode(mode), .threshold(threshold),
    .roi_x0(roi_x0), .roi_x1(roi_x1), .roi_y0(roi_y0), .roi_y1(roi_y1),
    .hit_level(hit_level), .algo_start(algo_start),
    .algo_busy(algo_busy), .algo_done(algo_done),
    .dark_count(dark_count), .result(result),
    .h_cnt(h_cnt), .v_cnt(v_cnt),
    .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync)
  );

  vga_roi_analyzer #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .IMG_W(IW), .IMG_H(IH), .IMG_X0(IX), .IMG_Y0(IY),
    .CW(4), .ADDR_W(17), .CNT_W(8), .SYNC_ACTIVE(0)
  ) u_sat (
    .clk25(clk), .rst(rst), .frame_addr(s_frame_addr), .frame_pixel(fb_pix),
    .mode(mode), .threshold(threshold),
    .roi_x0(roi_x0), .roi_x1(roi_x1), .roi_y0(roi_y0), .roi_y1(roi_y1),
    .hit_level(hit8), .algo_start(algo_start),
    .algo_busy(s_busy), .algo_done(s_done),
    .dark_count(s_dark), .result(s_result),
    .h_cnt(s_h), .v_cnt(s_v),
    .vga_red(s_r), .vga_green(s_g), .vga_blue(s_b),
    .vga_hsync(s_hs), .vga_vsync(s_vs)
  );

  always #20 clk = ~clk;

  // frame buffer: synchronous read, one cycle latency
  always @(posedge clk) fb_pix <= pat_addr ? (frame_addr[11:0] + 12'h001) : fb_const;

  // reference raster position
  always @(posedge clk) begin
    if (rst) begin
      mh <= 0; mv <= 0;
    end else if (mh == HT - 1) begin
      mh <= 0;
      mv <= (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh <= mh + 1;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out (t=%0t)", nm, $time);
  endtask

  function automatic int gray_of(input logic [11:0] p);
    return (int'(p[11:8]) / 4 + int'(p[7:4]) / 2 + int'(p[3:0]) / 4) % 16;
  endfunction

  // expected {R,G,B,hsync,vsync} for counter position (h,v)
  function automatic logic [13:0] model(input int h, input int v);
    logic inimg, roi, dark, hsn, vsn;
    logic [11:0] pix, rgb;
    logic [3:0]  gray, bw;
    int addr;
    inimg = (h >= IX) && (h < IX + IW) && (v >= IY) && (v < IY + IH);
    addr  = (v - IY) * IW + (h - IX);
    pix   = pat_addr ? 12'(addr + 1) : fb_const;
    gray  = 4'(gray_of(pix));
    dark  = (gray <= threshold);
    bw    = dark ? 4'h0 : 4'hF;
    roi   = inimg && h >= int'(roi_x0) && h <= int'(roi_x1)
                  && v >= int'(roi_y0) && v <= int'(roi_y1);
    case (mode)
      2'd0:    rgb = pix;
      2'd1:    rgb = {gray, gray, gray};
      2'd2:    rgb = {bw, bw, bw};
      default: rgb = (dark && roi) ? 12'h00F : {bw, bw, bw};
    endcase
    if (!inimg) rgb = 12'h000;
    hsn = !(h >= HA + HFP && h < HA + HFP + HS);
    vsn = !(v >= VA + VFP && v < VA + VFP + VS);
    return {rgb, hsn, vsn};
  endfunction

  // pixel/sync scoreboard: push at the counter cycle, compare two cycles later
  always @(negedge clk) begin
    if (sb_en) begin
      sb_q.push_back(model(mh, mv));
      if (sb_q.size() > 2) begin
        sb_e = sb_q.pop_front();
        check("pix_sync", {vga_red, vga_green, vga_blue, vga_hsync, vga_vsync}, sb_e);
      end
      check("h_cnt", h_cnt, mh);
      check("v_cnt", v_cnt, mv);
      if (mh >= IX && mh < IX + IW && mv >= IY && mv < IY + IH)
        check("frame_addr", frame_addr, (mv - IY) * IW + (mh - IX));
    end
  end

  task automatic wait_pos(input int h, input int v);
    bit ok = 0;
    for (int k = 0; k < 2 * FRAME; k++) begin
      @(negedge clk);
      if (mh == h && mv == v) begin ok = 1; break; end
    end
    if (!ok) fail_now("wait_pos");
  endtask

  task automatic set_cfg(input logic [1:0] md, input logic [3:0] thr, input logic pa,
                         input logic [11:0] pix, input int x0, input int x1,
                         input int y0, input int y1);
    @(posedge clk); #1;
    sb_en = 1'b0;
    sb_q.delete();
    mode = md; threshold = thr; pat_addr = pa; fb_const = pix;
    roi_x0 = 10'(x0); roi_x1 = 10'(x1); roi_y0 = 10'(y0); roi_y1 = 10'(y1);
    sb_en = 1'b1;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 algo_start = 1'b1;
    @(posedge clk); #1 algo_start = 1'b0;
  endtask

  task automatic meas(input string nm, input logic [11:0] pix, input logic [3:0] thr,
                      input int x0, input int x1, input int y0, input int y1,
                      input int hit, input int h8, input bit restart);
    int cx0, cx1, cy0, cy1, area;
    meas_t e, got;
    bit ok = 0;
    set_cfg(2'd3, thr, 1'b0, pix, x0, x1, y0, y1);
    hit_level = 17'(hit);
    hit8 = 8'(h8);
    cx0 = (x0 > IX) ? x0 : IX;
    cx1 = (x1 < IX + IW - 1) ? x1 : IX + IW - 1;
    cy0 = (y0 > IY) ? y0 : IY;
    cy1 = (y1 < IY + IH - 1) ? y1 : IY + IH - 1;
    area = (cx1 >= cx0 && cy1 >= cy0) ? (cx1 - cx0 + 1) * (cy1 - cy0 + 1) : 0;
    e.cnt  = (gray_of(pix) <= int'(thr)) ? area : 0;
    e.res  = (e.cnt >= hit);
    e.cnt8 = (e.cnt > 255) ? 255 : e.cnt;
    e.res8 = (e.cnt8 >= h8);
    mq.push_back(e);
    pulse_start();
    check({nm, "_start"}, {algo_busy, algo_done, result}, 3'b100);
    if (restart) begin
      wait_pos(0, 0);
      wait_pos(5, 12);
      pulse_start();
      check({nm, "_restart"}, {algo_busy, algo_done}, 2'b10);
    end
    for (int k = 0; k < 3 * FRAME; k++) begin
      @(negedge clk);
      if (algo_done) begin ok = 1; break; end
    end
    if (!ok) begin
      fail_now({nm, "_done"});
      void'(mq.pop_front());
    end else begin
      got = mq.pop_front();
      check({nm, "_pos"}, (mh << 16) | mv, (3 << 16) | (IY + IH));
      check({nm, "_count"}, dark_count, got.cnt);
      check({nm, "_result"}, result, got.res);
      check({nm, "_busy"}, {algo_busy, s_busy, s_done}, 3'b001);
      check({nm, "_count8"}, s_dark, got.cnt8);
      check({nm, "_result8"}, s_result, got.res8);
      repeat (5) @(negedge clk);
      check({nm, "_sticky"}, {algo_busy, algo_done, dark_count}, {2'b01, 17'(got.cnt)});
    end
  endtask

  pv_t tbl[13];
  int hs_low, vs_low, max_addr;

  initial begin
    tbl[0]  = '{2'd0, 4'd0,  12'hFFF, 12'hFFF, 12'hFFF};
    tbl[1]  = '{2'd1, 4'd0,  12'hFFF, 12'hDDD, 12'hDDD};
    tbl[2]  = '{2'd1, 4'd0,  12'h888, 12'h888, 12'h888};
    tbl[3]  = '{2'd2, 4'd7,  12'h888, 12'hFFF, 12'hFFF};
    tbl[4]  = '{2'd2, 4'd8,  12'h888, 12'h000, 12'h000};
    tbl[5]  = '{2'd3, 4'd8,  12'h888, 12'h00F, 12'h000};
    tbl[6]  = '{2'd3, 4'd7,  12'h888, 12'hFFF, 12'hFFF};
    tbl[7]  = '{2'd0, 4'd0,  12'h123, 12'h123, 12'h123};
    tbl[8]  = '{2'd1, 4'd0,  12'h123, 12'h111, 12'h111};
    tbl[9]  = '{2'd1, 4'd0,  12'hC84, 12'h888, 12'h888};
    tbl[10] = '{2'd3, 4'd15, 12'hFFF, 12'h00F, 12'h000};
    tbl[11] = '{2'd2, 4'd12, 12'hFFF, 12'hFFF, 12'hFFF};
    tbl[12] = '{2'd2, 4'd13, 12'hFFF, 12'h000, 12'h000};

    rst = 1'b1; algo_start = 1'b0; mode = 2'd0; threshold = 4'd4;
    pat_addr = 1'b1; fb_const = 12'h000;
    roi_x0 = 10'd12; roi_x1 = 10'd20; roi_y0 = 10'd10; roi_y1 = 10'd16;
    hit_level = '0; hit8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ctr", {h_cnt, v_cnt}, 0);
    check("reset_addr", frame_addr, 0);
    check("reset_rgb", {vga_red, vga_green, vga_blue}, 0);
    check("reset_sync", {vga_hsync, vga_vsync}, 2'b11);
    check("reset_fsm", {algo_busy, algo_done, result}, 0);
    check("reset_count", dark_count, 0);
    rst = 1'b0;
    sb_en = 1'b1;

    // free-run one frame: sync widths and address range
    hs_low = 0; vs_low = 0; max_addr = 0;
    for (int k = 0; k < FRAME; k++) begin
      @(negedge clk);
      if (!vga_hsync) hs_low++;
      if (!vga_vsync) vs_low++;
      if (int'(frame_addr) > max_addr) max_addr = int'(frame_addr);
    end
    check("hsync_low_cycles", hs_low, HS * VT);
    check("vsync_low_cycles", vs_low, VS * HT);
    check("frame_addr_max", max_addr, IW * IH - 1);
    wait_pos(IX + 1, IY);
    check("first_pix_before", {vga_red, vga_green, vga_blue}, 12'h000);
    @(negedge clk);
    check("first_pix", {vga_red, vga_green, vga_blue}, 12'h001);

    // pixel-path table: one in-ROI and one out-of-ROI sample per row
    for (int i = 0; i < 13; i++) begin
      set_cfg(tbl[i].mode, tbl[i].thr, 1'b0, tbl[i].pix, 12, 20, 10, 16);
      wait_pos(16, 11);
      check("tbl_in_roi", {vga_red, vga_green, vga_blue}, tbl[i].exp_in);
      wait_pos(27, 19);
      check("tbl_out_roi", {vga_red, vga_green, vga_blue}, tbl[i].exp_out);
    end

    // measurements
    meas("m_black",   12'h000, 4'd4, 12, 27,  9, 18, 150, 100, 1'b0);
    meas("m_gray8",   12'h888, 4'd0, 12, 27,  9, 18, 150,   1, 1'b0);
    meas("m_hit_eq",  12'h000, 4'd4, 12, 27,  9, 18, 160, 161, 1'b0);
    meas("m_restart", 12'h000, 4'd4, 12, 27,  9, 18, 161, 160, 1'b1);
    meas("m_empty",   12'h000, 4'd4, 25, 12,  9, 18,   0,   0, 1'b0);
    meas("m_single",  12'h000, 4'd4, 15, 15, 12, 12,   1,   2, 1'b0);
    meas("m_full",    12'h000, 4'd0,  0, 47,  0, 35, 280, 255, 1'b0);

    // reset in the middle of a measurement
    pulse_start();
    wait_pos(0, 0);
    wait_pos(5, 12);
    check("rst_pre_busy", {algo_busy, s_busy}, 2'b11);
    @(posedge clk); #1;
    sb_en = 1'b0;
    sb_q.delete();
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_fsm", {algo_busy, algo_done, result, s_busy, s_done, s_result}, 0);
    check("rst_mid_count", {dark_count, s_dark}, 0);
    rst = 1'b0;
    sb_en = 1'b1;
    repeat (HT * 3) @(negedge clk);
    check("rst_idle", {algo_busy, algo_done}, 2'b00);

    @(posedge clk); #1;
    sb_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
